// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Opcode/funct encodings, ALU operation and write-back select
//               types for the single-cycle MIPS32 subset core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Link register used by jal
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLLV,
    ALU_SRLV,
    ALU_SRAV
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile
// Description : 32x32 register file, two combinational read ports and one
//               clocked write port. Register $0 reads as zero and ignores
//               writes. Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // Single write port; writes aimed at $0 are dropped
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/mips32_processor.sv
`default_nettype none
// ============================================================================
// Module      : mips32_processor
// Description : Single-cycle MIPS32 subset core. Decoder, ALU and next-PC
//               selection live here; the register file is a sub-module.
//               One instruction retires per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_processor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        write_enable,
  output logic [31:0] address_to_mem,
  output logic [31:0] data_to_mem,
  input  logic [31:0] data_from_mem
);
  import mips_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic        unused_shamt;

  assign opcode       = instruction[31:26];
  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  assign funct        = instruction[5:0];
  assign imm_sext     = {{16{instruction[15]}}, instruction[15:0]};
  assign unused_shamt = ^instruction[10:6];

  // Control
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        use_imm;
  logic        reg_we;
  logic [4:0]  dst;
  logic        mem_we;
  logic        is_beq;
  logic        is_jump;
  logic        is_jr;

  // Datapath
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] wb_data;
  logic [31:0] pc_plus4;

  mips_regfile u_regfile (
    .clk      (clk),
    .we_i     (reg_we && reset),
    .waddr_i  (dst),
    .wdata_i  (wb_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val)
  );

  // Decode: anything not recognised falls through as a NOP (no writes, pc+4)
  always_comb begin
    alu_op  = ALU_ADD;
    wb_sel  = WB_ALU;
    use_imm = 1'b0;
    reg_we  = 1'b0;
    dst     = rd;
    mem_we  = 1'b0;
    is_beq  = 1'b0;
    is_jump = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLLV: alu_op = ALU_SLLV;
          FN_SRLV: alu_op = ALU_SRLV;
          FN_SRAV: alu_op = ALU_SRAV;
          FN_JR: begin
            reg_we = 1'b0;
            is_jr  = 1'b1;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        dst     = rt;
      end
      OP_LW: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        dst     = rt;
        wb_sel  = WB_MEM;
      end
      OP_SW: begin
        use_imm = 1'b1;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_JAL: begin
        is_jump = 1'b1;
        reg_we  = 1'b1;
        dst     = REG_RA;
        wb_sel  = WB_PC4;
      end
      default: ;
    endcase
  end

  // ALU: shifts take rt as the value and rs[4:0] as the amount
  always_comb begin
    alu_b = use_imm ? imm_sext : rt_val;
    case (alu_op)
      ALU_ADD:  alu_result = rs_val + alu_b;
      ALU_SUB:  alu_result = rs_val - alu_b;
      ALU_AND:  alu_result = rs_val & alu_b;
      ALU_OR:   alu_result = rs_val | alu_b;
      ALU_SLT:  alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLLV: alu_result = alu_b << rs_val[4:0];
      ALU_SRLV: alu_result = alu_b >> rs_val[4:0];
      ALU_SRAV: alu_result = $unsigned($signed(alu_b) >>> rs_val[4:0]);
      default:  alu_result = rs_val + alu_b;
    endcase
  end

  // Write-back source select
  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = data_from_mem;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  // Next-PC selection
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (is_jr) begin
      pc_d = rs_val;
    end else if (is_jump) begin
      pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
    end else if (is_beq && (rs_val == rt_val)) begin
      pc_d = pc_plus4 + (imm_sext << 2);
    end else begin
      pc_d = pc_plus4;
    end
  end

  // PC register; reset reloads RESET_PC but leaves the register file alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc             = pc_q;
  assign write_enable   = mem_we && reset;
  assign address_to_mem = alu_result;
  assign data_to_mem    = rt_val;

endmodule
`default_nettype wire

// File: tb/tb_mips32_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips32_processor
// Description : Scoreboard bench for mips32_processor. Instructions are
//               driven directly each cycle; an architectural model predicts
//               pc, store strobe, ALU address and store data per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_processor;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc;
  logic [31:0] instruction = 32'd0;
  logic        write_enable;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;

  mips32_processor #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instruction    (instruction),
    .write_enable   (write_enable),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem)
  );

  always #5 clk = ~clk;

  // ---------------- data memory (environment) ----------------
  function automatic logic [31:0] seed_word(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  logic [31:0] tb_mem [64];
  logic        mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= seed_word(i);
    end else if (write_enable) begin
      tb_mem[address_to_mem[7:2]] <= data_to_mem;
    end
  end
  assign data_from_mem = tb_mem[address_to_mem[7:2]];

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_addr;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, got, want);
    end
  endtask

  // Monitor: sample outputs 2 time units after the stimulus edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "pc", pc, e.pc);
        check(e.name, "we", {31'd0, write_enable}, {31'd0, e.we});
        if (e.chk_addr) check(e.name, "addr", address_to_mem, e.addr);
        if (e.chk_data) check(e.name, "data", data_to_mem, e.data);
      end
    end
  end

  // ---------------- architectural reference model ----------------
  logic [31:0] m_reg [32];
  bit          m_known [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

  task automatic model_apply(input logic rst_n, input logic [31:0] ins, input string nm);
    exp_t        e;
    logic [5:0]  op  = ins[31:26];
    logic [4:0]  rs  = ins[25:21];
    logic [4:0]  rt  = ins[20:16];
    logic [4:0]  rd  = ins[15:11];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] imm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] a   = m_reg[rs];
    logic [31:0] b   = m_reg[rt];
    bit          ka  = m_known[rs];
    bit          kb  = m_known[rt];
    logic [31:0] pc4 = m_pc + 32'd4;
    logic [31:0] nxt = pc4;
    logic [31:0] res = 32'd0;
    bit          alu = 1'b0;
    bit          wr  = 1'b0;
    logic [4:0]  wdst = 5'd0;
    logic [31:0] wd  = 32'd0;
    bit          wk  = 1'b0;

    e.name = nm; e.pc = m_pc; e.we = 1'b0; e.addr = 32'd0;
    e.data = b;  e.chk_data = kb; e.chk_addr = 1'b0;

    if (!rst_n) begin
      exp_q.push_back(e);
      m_pc = RESET_PC;
      return;
    end

    case (op)
      6'h00: begin
        alu = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h04: res = b << a[4:0];
          6'h06: res = b >> a[4:0];
          6'h07: res = $unsigned($signed(b) >>> a[4:0]);
          6'h08: begin alu = 1'b0; nxt = a; end
          default: alu = 1'b0;
        endcase
        if (alu) begin
          e.addr = res; e.chk_addr = ka && kb;
          wr = 1'b1; wdst = rd; wd = res; wk = ka && kb;
        end
      end
      6'h08: begin
        res = a + imm; e.addr = res; e.chk_addr = ka;
        wr = 1'b1; wdst = rt; wd = res; wk = ka;
      end
      6'h23: begin
        res = a + imm; e.addr = res; e.chk_addr = ka;
        wr = 1'b1; wdst = rt; wd = m_mem[res[7:2]]; wk = ka;
      end
      6'h2B: begin
        res = a + imm; e.addr = res; e.chk_addr = ka; e.we = 1'b1;
        if (ka) m_mem[res[7:2]] = b;
      end
      6'h04: if (a == b) nxt = pc4 + (imm << 2);
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        nxt = {pc4[31:28], ins[25:0], 2'b00};
        wr = 1'b1; wdst = 5'd31; wd = pc4; wk = 1'b1;
      end
      default: ;
    endcase

    exp_q.push_back(e);
    if (wr && wdst != 5'd0) begin
      m_reg[wdst]   = wd;
      m_known[wdst] = wk;
    end
    m_pc = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic rst_n, input logic [31:0] ins, input string nm);
    @(negedge clk);
    mem_init    = 1'b0;
    reset       = rst_n;
    instruction = ins;
    model_apply(rst_n, ins, nm);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  alu_fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h04, 6'h06, 6'h07};
    logic [5:0]  bad_op [3] = '{6'h0F, 6'h3F, 6'h0D};
    logic [5:0]  bad_fn [3] = '{6'h21, 6'h00, 6'h3F};
    logic [4:0]  rs  = 5'($urandom);
    logic [4:0]  rt  = 5'($urandom);
    logic [4:0]  rd  = 5'($urandom);
    logic [15:0] imm = 16'($urandom);
    int          k   = $urandom_range(0, 19);
    if (k <= 8)       return r_ins(rs, rt, rd, alu_fn[$urandom_range(0, 7)]);
    else if (k == 9)  return r_ins(rs, 5'd0, 5'd0, 6'h08);
    else if (k == 10) return r_ins(rs, rt, rd, bad_fn[$urandom_range(0, 2)]);
    else if (k <= 12 || k == 19) return i_ins(6'h08, rs, rt, imm);
    else if (k == 13) return i_ins(6'h23, rs, rt, imm);
    else if (k == 14) return i_ins(6'h2B, rs, rt, imm);
    else if (k == 15) return i_ins(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm);
    else if (k == 16) return {6'h02, 26'($urandom)};
    else if (k == 17) return {6'h03, 26'($urandom)};
    else              return i_ins(bad_op[$urandom_range(0, 2)], rs, rt, imm);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]   = 32'd0;
      m_known[i] = (i == 0);
    end
    for (int i = 0; i < 64; i++) m_mem[i] = seed_word(i);
    m_pc = RESET_PC;

    // Reset held for two edges while a store is presented
    issue(1'b0, i_ins(6'h2B, 5'd0, 5'd0, 16'd0), "rst0");
    issue(1'b0, i_ins(6'h2B, 5'd0, 5'd0, 16'd0), "rst1");
    issue(1'b1, 32'd0, "nop_pc0");
    issue(1'b1, 32'd0, "nop_pc4");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd1, 16'd5), "addi_r1");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD), "addi_r2");
    issue(1'b1, i_ins(6'h04, 5'd1, 5'd1, 16'hFFFF), "beq_loop");
    issue(1'b1, i_ins(6'h04, 5'd1, 5'd1, 16'hFFFF), "beq_loop2");
    issue(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'd5), "beq_ne");
    issue(1'b1, r_ins(5'd1, 5'd2, 5'd3, 6'h20), "add");
    issue(1'b1, r_ins(5'd1, 5'd2, 5'd4, 6'h22), "sub");
    issue(1'b1, r_ins(5'd2, 5'd1, 5'd4, 6'h2A), "slt");
    issue(1'b1, {6'h03, 26'h0000010}, "jal");
    issue(1'b1, r_ins(5'd31, 5'd0, 5'd0, 6'h08), "jr");
    issue(1'b1, i_ins(6'h2B, 5'd0, 5'd1, 16'd8), "sw");
    issue(1'b1, i_ins(6'h23, 5'd0, 5'd5, 16'd8), "lw");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd0, 16'd7), "addi_r0");
    issue(1'b1, i_ins(6'h2B, 5'd0, 5'd5, 16'd12), "sw_r5");
    issue(1'b1, i_ins(6'h2B, 5'd0, 5'd0, 16'd16), "sw_r0");
    issue(1'b1, i_ins(6'h2B, 5'd0, 5'd3, 16'd20), "sw_r3");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd6, 16'd1), "addi_r6");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd7, 16'd31), "addi_r7");
    issue(1'b1, r_ins(5'd7, 5'd6, 5'd6, 6'h04), "sllv");
    issue(1'b1, i_ins(6'h08, 5'd0, 5'd8, 16'd4), "addi_r8");
    issue(1'b1, r_ins(5'd8, 5'd6, 5'd9, 6'h07), "srav");
    issue(1'b1, r_ins(5'd8, 5'd6, 5'd10, 6'h06), "srlv");
    issue(1'b1, {6'h02, m_pc[27:2]}, "j_self");
    issue(1'b1, {6'h02, m_pc[27:2]}, "j_self2");
    issue(1'b1, {6'h02, 26'h0000020}, "j_fwd");

    // Give every register a known value before random traffic
    for (int r = 1; r < 32; r++) begin
      issue(1'b1, i_ins(6'h08, 5'd0, 5'(r), 16'($urandom)), "init");
    end

    // Random program with occasional mid-program resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) issue(1'b0, rand_instr(), "rand_rst");
      else                            issue(1'b1, rand_instr(), "rand");
    end

    repeat (3) @(negedge clk);
    #4;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
